// File: rtl/csr_regfile_if.sv
`default_nettype none
// ============================================================================
// Module      : csr_regfile_if
// Description : CSR read/write, trap and interrupt signals between the CSR
//               execute unit / trap controller (master) and the register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface csr_regfile_if;
  logic [11:0] csr_raddr;
  logic [31:0] csr_data;
  logic        csr_illegal;
  logic        csr_we;
  logic [11:0] csrw_addr;
  logic [31:0] csrw_data;
  logic        inst_retire;
  logic        trap_en;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_val;
  logic        mret;
  logic        irq_ext;
  logic        irq_timer;
  logic        irq_soft;
  logic [31:0] mtvec_out;
  logic [31:0] mepc_out;
  logic        irq_pending;

  modport master (
    output csr_raddr, csr_we, csrw_addr, csrw_data, inst_retire,
           trap_en, trap_cause, trap_pc, trap_val, mret,
           irq_ext, irq_timer, irq_soft,
    input  csr_data, csr_illegal, mtvec_out, mepc_out, irq_pending
  );

  modport slave (
    input  csr_raddr, csr_we, csrw_addr, csrw_data, inst_retire,
           trap_en, trap_cause, trap_pc, trap_val, mret,
           irq_ext, irq_timer, irq_soft,
    output csr_data, csr_illegal, mtvec_out, mepc_out, irq_pending
  );
endinterface
`default_nettype wire

// File: rtl/csr_regfile.sv
`default_nettype none
// ============================================================================
// Module      : csr_regfile
// Description : Machine-mode CSR file with 64-bit cycle/instret counters,
//               trap entry/return updates and interrupt-pending summary.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_regfile #(
  parameter logic [31:0] MISA_VAL = 32'h4000_0100,
  parameter logic [31:0] HART_ID  = 32'h0000_0000
) (
  input  wire logic   clk,
  input  wire logic   rst,
  csr_regfile_if.slave bus
);

  localparam logic [11:0] c_MSTATUS   = 12'h300;
  localparam logic [11:0] c_MISA      = 12'h301;
  localparam logic [11:0] c_MIE       = 12'h304;
  localparam logic [11:0] c_MTVEC     = 12'h305;
  localparam logic [11:0] c_MSCRATCH  = 12'h340;
  localparam logic [11:0] c_MEPC      = 12'h341;
  localparam logic [11:0] c_MCAUSE    = 12'h342;
  localparam logic [11:0] c_MTVAL     = 12'h343;
  localparam logic [11:0] c_MIP       = 12'h344;
  localparam logic [11:0] c_MCYCLE    = 12'hB00;
  localparam logic [11:0] c_MINSTRET  = 12'hB02;
  localparam logic [11:0] c_MCYCLEH   = 12'hB80;
  localparam logic [11:0] c_MINSTRETH = 12'hB82;
  localparam logic [11:0] c_CYCLE     = 12'hC00;
  localparam logic [11:0] c_INSTRET   = 12'hC02;
  localparam logic [11:0] c_CYCLEH    = 12'hC80;
  localparam logic [11:0] c_INSTRETH  = 12'hC82;
  localparam logic [11:0] c_MHARTID   = 12'hF14;
  localparam logic [31:0] c_MIE_MASK  = 32'h0000_0888;

  logic        r_mstatus_mie;
  logic        r_mstatus_mpie;
  logic [31:0] r_mie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;
  logic [63:0] r_mcycle;
  logic [63:0] r_minstret;

  logic [31:0] w_mstatus;
  logic [31:0] w_mip;
  logic [31:0] w_rdata;
  logic        w_illegal;
  logic [63:0] w_mcycle_nxt;
  logic [63:0] w_minstret_nxt;

  logic w_wr_mstatus, w_wr_mie, w_wr_mtvec, w_wr_mscratch;
  logic w_wr_mepc, w_wr_mcause, w_wr_mtval;
  logic w_wr_mcycle, w_wr_mcycleh, w_wr_minstret, w_wr_minstreth;

  // A written half holds the written value; the carry into the high half is
  // taken from whatever value the low half ends up based on this cycle.
  function automatic logic [63:0] f_count(
    input logic [63:0] cur,
    input logic        inc,
    input logic        wr_lo,
    input logic        wr_hi,
    input logic [31:0] wdata
  );
    logic [31:0] w_lo_base;
    logic [31:0] w_lo;
    logic [31:0] w_hi;
    logic        w_carry;
    w_lo_base = wr_lo ? wdata : cur[31:0];
    w_carry   = inc & (w_lo_base == 32'hFFFF_FFFF);
    w_lo      = wr_lo ? wdata : cur[31:0] + {31'b0, inc};
    w_hi      = wr_hi ? wdata : cur[63:32] + {31'b0, w_carry};
    return {w_hi, w_lo};
  endfunction

  assign w_wr_mstatus   = bus.csr_we && (bus.csrw_addr == c_MSTATUS);
  assign w_wr_mie       = bus.csr_we && (bus.csrw_addr == c_MIE);
  assign w_wr_mtvec     = bus.csr_we && (bus.csrw_addr == c_MTVEC);
  assign w_wr_mscratch  = bus.csr_we && (bus.csrw_addr == c_MSCRATCH);
  assign w_wr_mepc      = bus.csr_we && (bus.csrw_addr == c_MEPC);
  assign w_wr_mcause    = bus.csr_we && (bus.csrw_addr == c_MCAUSE);
  assign w_wr_mtval     = bus.csr_we && (bus.csrw_addr == c_MTVAL);
  assign w_wr_mcycle    = bus.csr_we && (bus.csrw_addr == c_MCYCLE);
  assign w_wr_mcycleh   = bus.csr_we && (bus.csrw_addr == c_MCYCLEH);
  assign w_wr_minstret  = bus.csr_we && (bus.csrw_addr == c_MINSTRET);
  assign w_wr_minstreth = bus.csr_we && (bus.csrw_addr == c_MINSTRETH);

  assign w_mcycle_nxt   = f_count(r_mcycle, 1'b1, w_wr_mcycle, w_wr_mcycleh,
                                  bus.csrw_data);
  assign w_minstret_nxt = f_count(r_minstret, bus.inst_retire, w_wr_minstret,
                                  w_wr_minstreth, bus.csrw_data);

  assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};
  assign w_mip     = {20'b0, bus.irq_ext, 3'b0, bus.irq_timer, 3'b0, bus.irq_soft, 3'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= '0;
      r_mtvec        <= '0;
      r_mscratch     <= '0;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_mtval        <= '0;
      r_mcycle       <= '0;
      r_minstret     <= '0;
    end else begin
      if (bus.trap_en) begin
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else if (bus.mret) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end else if (w_wr_mstatus) begin
        r_mstatus_mie  <= bus.csrw_data[3];
        r_mstatus_mpie <= bus.csrw_data[7];
      end

      // Trap state wins over a same-cycle write to the same register only.
      if (bus.trap_en) begin
        r_mepc   <= bus.trap_pc & ~32'h3;
        r_mcause <= bus.trap_cause;
        r_mtval  <= bus.trap_val;
      end else begin
        if (w_wr_mepc)   r_mepc   <= bus.csrw_data & ~32'h3;
        if (w_wr_mcause) r_mcause <= bus.csrw_data;
        if (w_wr_mtval)  r_mtval  <= bus.csrw_data;
      end

      if (w_wr_mie)      r_mie      <= bus.csrw_data & c_MIE_MASK;
      if (w_wr_mtvec)    r_mtvec    <= bus.csrw_data & ~32'h3;
      if (w_wr_mscratch) r_mscratch <= bus.csrw_data;

      r_mcycle   <= w_mcycle_nxt;
      r_minstret <= w_minstret_nxt;
    end
  end

  always_comb begin
    w_rdata   = '0;
    w_illegal = 1'b0;
    case (bus.csr_raddr)
      c_MSTATUS:              w_rdata = w_mstatus;
      c_MISA:                 w_rdata = MISA_VAL;
      c_MIE:                  w_rdata = r_mie;
      c_MTVEC:                w_rdata = r_mtvec;
      c_MSCRATCH:             w_rdata = r_mscratch;
      c_MEPC:                 w_rdata = r_mepc;
      c_MCAUSE:               w_rdata = r_mcause;
      c_MTVAL:                w_rdata = r_mtval;
      c_MIP:                  w_rdata = w_mip;
      c_MCYCLE,    c_CYCLE:   w_rdata = r_mcycle[31:0];
      c_MCYCLEH,   c_CYCLEH:  w_rdata = r_mcycle[63:32];
      c_MINSTRET,  c_INSTRET: w_rdata = r_minstret[31:0];
      c_MINSTRETH, c_INSTRETH: w_rdata = r_minstret[63:32];
      c_MHARTID:              w_rdata = HART_ID;
      default:                w_illegal = 1'b1;
    endcase
  end

  assign bus.csr_data    = w_rdata;
  assign bus.csr_illegal = w_illegal;
  assign bus.mtvec_out   = r_mtvec;
  assign bus.mepc_out    = r_mepc;
  assign bus.irq_pending = r_mstatus_mie & (|(r_mie & w_mip));

endmodule
`default_nettype wire

// File: tb/tb_csr_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_regfile
// Description : Directed plus randomized bench for csr_regfile against a
//               behavioural CSR model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_regfile;

  logic clk = 1'b0;
  logic rst;
  always #50 clk = ~clk;

  csr_regfile_if bus();
  csr_regfile dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic        m_mie, m_mpie;
  logic [31:0] m_ie, m_tvec, m_scratch, m_epc, m_cause, m_tval;
  logic [63:0] m_cyc, m_ret;

  logic [11:0] addrs [0:21] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340,
                                12'h341, 12'h342, 12'h343, 12'h344, 12'hB00,
                                12'hB02, 12'hB80, 12'hB82, 12'hC00, 12'hC02,
                                12'hC80, 12'hC82, 12'hF14, 12'h7C0, 12'h306,
                                12'h000, 12'hB01};

  // 64-bit counter step: a written half replaces its value; the high half
  // gains one only from a carry out of the (possibly written) low half.
  function automatic logic [63:0] cnt_next(logic [63:0] cur, logic inc,
                                           logic wlo, logic whi, logic [31:0] w);
    logic [63:0] n;
    logic [31:0] hi;
    if (wlo) begin
      hi = cur[63:32];
      if (inc && w == 32'hFFFF_FFFF) hi = hi + 32'd1;
      return {hi, w};
    end
    n = cur + 64'(inc);
    if (whi) return {w, n[31:0]};
    return n;
  endfunction

  function automatic logic [31:0] mip_val();
    return (32'(bus.irq_ext) << 11) | (32'(bus.irq_timer) << 7) | (32'(bus.irq_soft) << 3);
  endfunction

  task automatic model_step();
    logic [11:0] a;
    logic [31:0] d;
    logic        we;
    if (rst) begin
      m_mie = 0; m_mpie = 0; m_ie = 0; m_tvec = 0; m_scratch = 0;
      m_epc = 0; m_cause = 0; m_tval = 0; m_cyc = 0; m_ret = 0;
      return;
    end
    a = bus.csrw_addr; d = bus.csrw_data; we = bus.csr_we;
    m_cyc = cnt_next(m_cyc, 1'b1, we && a == 12'hB00, we && a == 12'hB80, d);
    m_ret = cnt_next(m_ret, bus.inst_retire, we && a == 12'hB02, we && a == 12'hB82, d);
    if (bus.trap_en) begin
      m_mpie = m_mie; m_mie = 0;
      m_epc = bus.trap_pc & ~32'h3; m_cause = bus.trap_cause; m_tval = bus.trap_val;
    end else if (bus.mret) begin
      m_mie = m_mpie; m_mpie = 1;
    end else if (we && a == 12'h300) begin
      m_mie = d[3]; m_mpie = d[7];
    end
    if (we && !bus.trap_en) begin
      if (a == 12'h341) m_epc = d & ~32'h3;
      if (a == 12'h342) m_cause = d;
      if (a == 12'h343) m_tval = d;
    end
    if (we && a == 12'h304) m_ie = d & 32'h888;
    if (we && a == 12'h305) m_tvec = d & ~32'h3;
    if (we && a == 12'h340) m_scratch = d;
  endtask

  task automatic exp_read(input logic [11:0] a, output logic [31:0] v, output logic ill);
    ill = 0;
    case (a)
      12'h300: v = 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h301: v = 32'h4000_0100;
      12'h304: v = m_ie;
      12'h305: v = m_tvec;
      12'h340: v = m_scratch;
      12'h341: v = m_epc;
      12'h342: v = m_cause;
      12'h343: v = m_tval;
      12'h344: v = mip_val();
      12'hB00, 12'hC00: v = m_cyc[31:0];
      12'hB80, 12'hC80: v = m_cyc[63:32];
      12'hB02, 12'hC02: v = m_ret[31:0];
      12'hB82, 12'hC82: v = m_ret[63:32];
      12'hF14: v = 32'h0;
      default: begin v = 0; ill = 1; end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_read(input logic [11:0] a);
    logic [31:0] v;
    logic        ill;
    bus.csr_raddr = a;
    #1;
    exp_read(a, v, ill);
    chk($sformatf("rd_%h", a), bus.csr_data, v);
    chk($sformatf("ill_%h", a), 32'(bus.csr_illegal), 32'(ill));
  endtask

  task automatic chk_outs();
    chk("mtvec_out", bus.mtvec_out, m_tvec);
    chk("mepc_out", bus.mepc_out, m_epc);
    chk("irq_pending", 32'(bus.irq_pending), 32'(m_mie && ((m_ie & mip_val()) != 0)));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.csr_we = 0; bus.csrw_addr = 0; bus.csrw_data = 0; bus.inst_retire = 0;
    bus.trap_en = 0; bus.trap_cause = 0; bus.trap_pc = 0; bus.trap_val = 0;
    bus.mret = 0; bus.irq_ext = 0; bus.irq_timer = 0; bus.irq_soft = 0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    bus.csr_we = 1; bus.csrw_addr = a; bus.csrw_data = d;
  endtask

  initial begin
    int r;
    idle();
    bus.csr_raddr = 0;
    rst = 1;
    tick();
    rst = 0;
    chk_outs();
    chk_read(12'h300);
    chk("rst_mstatus", bus.csr_data, 32'h1800);

    repeat (10) tick();
    chk_read(12'hB00); chk("mcycle10", bus.csr_data, 32'd10);
    chk_read(12'hB80); chk("mcycleh0", bus.csr_data, 32'd0);
    chk_read(12'hB02); chk("minstret0", bus.csr_data, 32'd0);
    chk_read(12'h301); chk("misa", bus.csr_data, 32'h4000_0100);

    wr(12'h305, 32'h8000_0103);
    chk_read(12'h305); chk("mtvec_rdw_old", bus.csr_data, 32'h0);
    tick(); idle();
    chk_read(12'h305); chk("mtvec_new", bus.csr_data, 32'h8000_0100);
    chk_outs();

    wr(12'h300, 32'h8); tick();
    wr(12'h304, 32'h80); tick();
    idle(); bus.irq_timer = 1;
    chk_read(12'h344); chk("mip_timer", bus.csr_data, 32'h80);
    chk("irq_pend_on", 32'(bus.irq_pending), 32'd1);
    wr(12'h300, 32'h0); tick();
    chk("irq_pend_off", 32'(bus.irq_pending), 32'd0);
    chk_outs();

    idle(); wr(12'h300, 32'h8); tick();
    idle();
    bus.trap_en = 1; bus.trap_pc = 32'h1006; bus.trap_cause = 32'h8000_0007;
    bus.trap_val = 32'h55;
    wr(12'h340, 32'hCAFE_0001);
    tick(); idle();
    chk_read(12'h341); chk("mepc_trap", bus.csr_data, 32'h1004);
    chk_read(12'h342); chk("mcause_trap", bus.csr_data, 32'h8000_0007);
    chk_read(12'h343); chk("mtval_trap", bus.csr_data, 32'h55);
    chk_read(12'h300); chk("mstatus_trap", bus.csr_data, 32'h1880);
    chk_read(12'h340); chk("mscratch_with_trap", bus.csr_data, 32'hCAFE_0001);
    bus.mret = 1; tick(); idle();
    chk_read(12'h300); chk("mstatus_mret", bus.csr_data, 32'h1888);

    bus.trap_en = 1; bus.trap_pc = 32'h2000; wr(12'h341, 32'h3333_3333);
    tick(); idle();
    chk_read(12'h341); chk("trap_beats_mepc_wr", bus.csr_data, 32'h2000);

    wr(12'hB00, 32'hFFFF_FFFE); tick();
    wr(12'hB80, 32'h0); tick(); idle(); tick();
    chk_read(12'hB80); chk("mcycleh_carry", bus.csr_data, 32'd1);
    chk_read(12'hB00); chk("mcycle_wrap", bus.csr_data, 32'd0);

    wr(12'h7C0, 32'h1234_5678);
    bus.csr_raddr = 12'h7C0; #1;
    chk("ill_7c0", 32'(bus.csr_illegal), 32'd1);
    chk("rd_7c0", bus.csr_data, 32'd0);
    tick(); idle();
    wr(12'h301, 32'hFFFF_FFFF); tick(); idle();
    chk_read(12'h301); chk("misa_ro", bus.csr_data, 32'h4000_0100);
    chk_read(12'h340);

    wr(12'h340, 32'hDEAD_BEEF); tick();
    wr(12'h340, 32'h1111_2222); rst = 1; tick(); rst = 0; idle();
    chk_read(12'h340); chk("mscratch_rst", bus.csr_data, 32'h0);
    chk_outs();

    for (int i = 0; i < 500; i++) begin
      idle();
      rst = ($urandom_range(0, 99) == 0);
      bus.csr_we = $urandom_range(0, 1);
      bus.csrw_addr = addrs[$urandom_range(0, 21)];
      r = $urandom_range(0, 7);
      bus.csrw_data = (r == 0) ? 32'hFFFF_FFFF : (r == 1) ? 32'hFFFF_FFFE : $urandom;
      bus.inst_retire = $urandom_range(0, 1);
      bus.trap_en = ($urandom_range(0, 11) == 0);
      bus.mret = ($urandom_range(0, 7) == 0);
      bus.trap_cause = $urandom; bus.trap_pc = $urandom; bus.trap_val = $urandom;
      bus.irq_ext = $urandom_range(0, 1);
      bus.irq_timer = $urandom_range(0, 1);
      bus.irq_soft = $urandom_range(0, 1);
      chk_read(addrs[$urandom_range(0, 21)]);
      chk_outs();
      tick();
      rst = 0;
      chk_outs();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
